// File: rtl/line_ring_buffer.sv
// line_ring_buffer: circular store of up to NUM_LINES complete image lines.
// Lines arrive as a raster stream and are released oldest-first. Readers
// address held lines by index relative to the oldest line plus a word offset.
// Read latency is three cycles (address reg, RAM read, output reg).
// Optional feature macro: LINE_RING_BUFFER_ERR_EN enables the sticky
// overflow/underflow flags; when undefined both flags are tied low.
module line_ring_buffer #(
  parameter int DATA_WIDTH = 144,
  parameter int LINE_WORDS = 57,
  parameter int NUM_LINES  = 16
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_frame_start,
  input  logic                             i_wr_valid,
  output logic                             o_wr_ready,
  input  logic [DATA_WIDTH-1:0]            i_wr_data,
  output logic [$clog2(NUM_LINES+1)-1:0]   o_lines_avail,
  input  logic                             i_line_release,
  input  logic                             i_rd_en,
  input  logic [$clog2(NUM_LINES)-1:0]     i_rd_line,
  input  logic [$clog2(LINE_WORDS)-1:0]    i_rd_word,
  output logic [DATA_WIDTH-1:0]            o_rd_data,
  output logic                             o_rd_valid,
  output logic                             o_err_overflow,
  output logic                             o_err_underflow
);

  localparam int DEPTH  = LINE_WORDS * NUM_LINES;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LINE_W = $clog2(NUM_LINES);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int CNT_W  = $clog2(NUM_LINES + 1);

  logic [WORD_W-1:0] wr_word_q, wr_word_d;
  logic [LINE_W-1:0] wr_line_q, wr_line_d;
  logic [LINE_W-1:0] rd_base_q, rd_base_d;
  logic [CNT_W-1:0]  lines_avail_q, lines_avail_d;

  logic              wr_ready;
  logic              wr_acc;
  logic              word_last;
  logic              line_done;
  logic              rel_ok;
  logic [ADDR_W-1:0] wr_addr;

  logic [LINE_W:0]   rd_sum;
  logic [LINE_W-1:0] rd_phys;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]        rd_vld_q, rd_vld_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  assign wr_ready      = (lines_avail_q != CNT_W'(NUM_LINES));
  assign o_wr_ready    = wr_ready;
  assign o_lines_avail = lines_avail_q;
  assign o_rd_valid    = rd_vld_q[2];
  assign o_rd_data     = rd_data_q;

  // Write/release bookkeeping; reset and frame start both restart the ring at slot 0
  always_comb begin
    wr_acc    = i_wr_valid && wr_ready && !i_reset;
    word_last = (wr_word_q == WORD_W'(LINE_WORDS - 1));
    line_done = wr_acc && word_last && !i_frame_start;
    rel_ok    = i_line_release && (lines_avail_q != '0) && !i_frame_start && !i_reset;
    wr_addr   = i_frame_start ? '0
              : ADDR_W'(wr_line_q) * ADDR_W'(LINE_WORDS) + ADDR_W'(wr_word_q);

    wr_word_d     = wr_word_q;
    wr_line_d     = wr_line_q;
    rd_base_d     = rd_base_q;
    lines_avail_d = lines_avail_q;

    if (i_reset || i_frame_start) begin
      // a write accepted alongside frame start lands at word 0 of slot 0
      wr_word_d     = wr_acc ? WORD_W'(1) : '0;
      wr_line_d     = '0;
      rd_base_d     = '0;
      lines_avail_d = '0;
    end else begin
      if (wr_acc)
        wr_word_d = word_last ? '0 : wr_word_q + 1'b1;
      if (line_done)
        wr_line_d = (wr_line_q == LINE_W'(NUM_LINES - 1)) ? '0 : wr_line_q + 1'b1;
      if (rel_ok)
        rd_base_d = (rd_base_q == LINE_W'(NUM_LINES - 1)) ? '0 : rd_base_q + 1'b1;
      case ({line_done, rel_ok})
        2'b10:   lines_avail_d = lines_avail_q + 1'b1;
        2'b01:   lines_avail_d = lines_avail_q - 1'b1;
        default: lines_avail_d = lines_avail_q;
      endcase
    end
  end

  // Relative line index to physical slot by one conditional subtract, then to RAM address
  always_comb begin
    rd_sum    = {1'b0, rd_base_q} + {1'b0, i_rd_line};
    rd_phys   = (rd_sum >= (LINE_W + 1)'(NUM_LINES))
              ? LINE_W'(rd_sum - (LINE_W + 1)'(NUM_LINES))
              : LINE_W'(rd_sum);
    rd_addr_d = ADDR_W'(rd_phys) * ADDR_W'(LINE_WORDS) + ADDR_W'(i_rd_word);
    rd_vld_d  = {rd_vld_q[1:0], i_rd_en};
  end

  // Pointer, count and read-valid pipeline registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_word_q     <= '0;
      wr_line_q     <= '0;
      rd_base_q     <= '0;
      lines_avail_q <= '0;
      rd_vld_q      <= '0;
      rd_data_q     <= '0;
    end else begin
      wr_word_q     <= wr_word_d;
      wr_line_q     <= wr_line_d;
      rd_base_q     <= rd_base_d;
      lines_avail_q <= lines_avail_d;
      rd_vld_q      <= rd_vld_d;
      rd_data_q     <= ram_q;
    end
  end

  // Read address register; frame start deliberately leaves in-flight reads alone
  always_ff @(posedge i_clk) begin
    rd_addr_q <= rd_addr_d;
  end

  // Simple dual-port RAM body, kept reset-free so it maps onto block RAM
  always_ff @(posedge i_clk) begin
    if (wr_acc)
      mem[wr_addr] <= i_wr_data;
    ram_q <= mem[rd_addr_q];
  end

`ifdef LINE_RING_BUFFER_ERR_EN
  logic err_ovf_q, err_ovf_d;
  logic err_unf_q, err_unf_d;

  // Sticky flags: writes offered while full, releases or reads beyond the held lines
  always_comb begin
    err_ovf_d = err_ovf_q | (i_wr_valid & ~wr_ready);
    err_unf_d = err_unf_q
              | (i_line_release && (lines_avail_q == '0))
              | (i_rd_en && (CNT_W'(i_rd_line) >= lines_avail_q));
  end

  // Only reset clears the flags; frame start keeps them
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign o_err_overflow  = err_ovf_q;
  assign o_err_underflow = err_unf_q;
`else
  assign o_err_overflow  = 1'b0;
  assign o_err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_line_ring_buffer.sv
// Bench for line_ring_buffer with 4-word lines and 3 slots. A logical line
// model predicts read data; expected reads go into a scoreboard queue when
// issued and are matched against o_rd_valid/o_rd_data three cycles later.
module tb_line_ring_buffer;
  localparam int DW     = 16;
  localparam int LW     = 4;
  localparam int NL     = 3;
  localparam int LINE_W = 2;
  localparam int WORD_W = 2;
  localparam int CNT_W  = 2;
`ifdef LINE_RING_BUFFER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              i_reset = 1'b0, i_frame_start = 1'b0, i_wr_valid = 1'b0;
  logic              i_line_release = 1'b0, i_rd_en = 1'b0;
  logic [DW-1:0]     i_wr_data = '0;
  logic [LINE_W-1:0] i_rd_line = '0;
  logic [WORD_W-1:0] i_rd_word = '0;
  logic              o_wr_ready, o_rd_valid, o_err_overflow, o_err_underflow;
  logic [CNT_W-1:0]  o_lines_avail;
  logic [DW-1:0]     o_rd_data;

  always #5 clk = ~clk;

  line_ring_buffer #(.DATA_WIDTH(DW), .LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_frame_start  (i_frame_start),
    .i_wr_valid     (i_wr_valid),
    .o_wr_ready     (o_wr_ready),
    .i_wr_data      (i_wr_data),
    .o_lines_avail  (o_lines_avail),
    .i_line_release (i_line_release),
    .i_rd_en        (i_rd_en),
    .i_rd_line      (i_rd_line),
    .i_rd_word      (i_rd_word),
    .o_rd_data      (o_rd_data),
    .o_rd_valid     (o_rd_valid),
    .o_err_overflow (o_err_overflow),
    .o_err_underflow(o_err_underflow)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit started = 1'b0;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } sb_t;
  sb_t sb[$];

  logic [LW*DW-1:0] held[$];
  logic [LW*DW-1:0] cur = '0;
  int               cur_n = 0;
  bit               m_ovf = 1'b0, m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [LW*DW-1:0] ln, input int w);
    return ln[w*DW +: DW];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // read monitor: valid must appear exactly 3 cycles after issue, in order
  always @(negedge clk) begin
    bit  exp_v;
    sb_t e;
    if (started) begin
      exp_v = (sb.size() > 0) && (sb[0].c + 3 == cyc);
      if (o_rd_valid || exp_v) begin
        chk("rd_valid", 32'(o_rd_valid), 32'(exp_v));
        if (exp_v) begin
          e = sb.pop_front();
          if (o_rd_valid) chk("rd_data", 32'(o_rd_data), 32'(e.d));
        end
      end
    end
  end

  // one clock of stimulus; model advances alongside, then per-cycle status checks
  task automatic drive(input bit wv, input logic [DW-1:0] wd, input bit rel, input bit fs,
                       input bit rd, input int rl, input int rw, input bit rst);
    bit full, acc;
    full = (held.size() == NL);
    acc  = wv && !full && !rst;
    i_wr_valid = wv; i_wr_data = wd; i_line_release = rel; i_frame_start = fs;
    i_rd_en = rd; i_rd_line = LINE_W'(rl); i_rd_word = WORD_W'(rw); i_reset = rst;
    if (rd && !rst && rl < held.size())
      sb.push_back('{d: word_of(held[rl], rw), c: cyc});
    if (ERR_EN && !rst) begin
      if (wv && full) m_ovf = 1'b1;
      if ((rel && held.size() == 0) || (rd && rl >= held.size())) m_unf = 1'b1;
    end
    if (rst) begin
      held.delete(); cur_n = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else if (fs) begin
      held.delete(); cur_n = 0;
      if (acc) begin cur[DW-1:0] = wd; cur_n = 1; end
    end else begin
      if (rel && held.size() > 0) void'(held.pop_front());
      if (acc) begin
        cur[cur_n*DW +: DW] = wd;
        cur_n++;
        if (cur_n == LW) begin held.push_back(cur); cur_n = 0; end
      end
    end
    @(posedge clk); #1;
    i_wr_valid = 1'b0; i_line_release = 1'b0; i_frame_start = 1'b0;
    i_rd_en = 1'b0; i_reset = 1'b0;
    chk("avail", 32'(o_lines_avail), 32'(held.size()));
    chk("wr_ready", 32'(o_wr_ready), 32'(held.size() != NL));
    chk("err_ovf", 32'(o_err_overflow), 32'(m_ovf));
    chk("err_unf", 32'(o_err_underflow), 32'(m_unf));
  endtask

  task automatic wr(input int d);      drive(1, DW'(d), 0, 0, 0, 0, 0, 0); endtask
  task automatic rel();                drive(0, '0, 1, 0, 0, 0, 0, 0);     endtask
  task automatic rd(input int l, input int w); drive(0, '0, 0, 0, 1, l, w, 0); endtask
  task automatic idle(input int n);    repeat (n) drive(0, '0, 0, 0, 0, 0, 0, 0); endtask
  task automatic rst();
    drive(0, '0, 0, 0, 0, 0, 0, 1);
    drive(0, '0, 0, 0, 0, 0, 0, 1);
  endtask
  task automatic drain();
    idle(5);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst();
    started = 1'b1;
    chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_rd_data", 32'(o_rd_data), 32'd0);
    chk("rst_ready", 32'(o_wr_ready), 32'd1);

    // fill to full, hold word 12, release frees one slot, then back-to-back reads
    for (int i = 0; i < 12; i++) wr(i);
    chk("fill_avail", 32'(o_lines_avail), 32'd3);
    chk("fill_ready", 32'(o_wr_ready), 32'd0);
    wr(12);
    wr(12);
    drive(1, DW'(12), 1, 0, 0, 0, 0, 0);
    chk("rel_ready", 32'(o_wr_ready), 32'd1);
    for (int l = 0; l < 2; l++)
      for (int w = 0; w < LW; w++) rd(l, w);
    drain();

    // wrap-around into slot 0
    rst();
    for (int i = 0; i < 12; i++) wr(i);
    rel();
    for (int i = 100; i < 104; i++) wr(i);
    rd(2, 1);
    rd(0, 0);
    drain();

    // line completion and release in the same cycle
    rst();
    for (int i = 0; i < 4; i++) wr(i);
    for (int i = 10; i < 14; i++) wr(i);
    for (int i = 20; i < 23; i++) wr(i);
    drive(1, DW'(23), 1, 0, 0, 0, 0, 0);
    chk("sim_avail", 32'(o_lines_avail), 32'd2);
    rd(0, 0);
    rd(1, 3);
    drain();

    // frame start mid-line with a write in the same cycle, read in flight across frame start
    rst();
    for (int i = 0; i < 6; i++) wr(i);
    drive(1, DW'(16'h00AA), 0, 1, 0, 0, 0, 0);
    chk("fs_avail", 32'(o_lines_avail), 32'd0);
    wr(16'hB1); wr(16'hB2); wr(16'hB3);
    chk("fs_line", 32'(o_lines_avail), 32'd1);
    rd(0, 0);
    rd(0, 3);
    rd(0, 1);
    drive(0, '0, 0, 1, 0, 0, 0, 0);
    drain();

    // error flags
    rst();
    rel();
    chk("unf_rel", 32'(o_err_underflow), 32'(ERR_EN));
    drive(0, '0, 0, 1, 0, 0, 0, 0);
    chk("unf_fs", 32'(o_err_underflow), 32'(ERR_EN));
    for (int i = 0; i < 12; i++) wr(i + 50);
    wr(99);
    chk("ovf_full", 32'(o_err_overflow), 32'(ERR_EN));
    rst();
    chk("rst_ovf", 32'(o_err_overflow), 32'd0);
    chk("rst_unf", 32'(o_err_underflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end
endmodule
